// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the E stage.
//   Owns HI/LO, accepts mult/multu/div/divu/mthi/mtlo from E and counts out
//   the operation latency, asserting a stall for HI/LO users held in D.
// Ports:
//   clk, reset_n      rising-edge clock, async active-low reset
//   start, op, a, b   E-stage MD request (op: 0 MULT,1 MULTU,2 DIV,3 DIVU,
//                     4 MTHI,5 MTLO, 6/7 no-op), operands already forwarded
//   md_in_d           D-stage instruction touches the MD unit
//   busy              operation in flight
//   hi, lo            architectural HI/LO registers
//   stall             hold F/D, bubble E
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  op_q;   // op[2] is never latched: only ops 0..3 enter RUN
  logic [31:0] a_q, b_q;

  // Result is formed from the latched operands; only written on the final edge.
  logic [63:0] prod_s, prod_u;
  logic        sdiv, a_neg, b_neg, dz;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_res, r_res;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    // Truncated 64x64 product of sign-extended operands is the exact signed product.
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    sdiv   = (op_q == 2'd2);
    a_neg  = sdiv & a_q[31];
    b_neg  = sdiv & b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    q_res  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_res  = a_neg ? -r_mag : r_mag;
    dz     = op_q[1] & (b_q == 32'd0);
    if (op_q[1]) begin
      res_hi = r_res;
      res_lo = q_res;
    end else if (op_q[0]) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 4'd0;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state <= RUN;
                busy  <= 1'b1;
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                cnt   <= op[1] ? DIV_N : MULT_N;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Requests arriving here are dropped; the in-flight op is untouched.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!dz) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // start term covers the cycle the MD op itself sits in E.
  assign stall = md_in_d & (busy | start);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        md_in_d = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .md_in_d(md_in_d), .busy(busy), .hi(hi), .lo(lo), .stall(stall)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining busy cycles plus architectural HI/LO.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_dz = 0;
  logic        last_stall;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          ncyc;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    longint sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up, uq, ur;
    sx = $signed(x); sy = $signed(y);
    ux = x; uy = y;
    dz = 0; rh = 0; rl = 0;
    case (o)
      3'd0: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
      3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      3'd2: if (y == 0) dz = 1; else begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
      default: if (y == 0) dz = 1; else begin uq = ux / uy; ur = ux % uy; rl = uq[31:0]; rh = ur[31:0]; end
    endcase
  endfunction

  function automatic void model_edge();
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      if (op <= 3) begin
        m_left = (op < 2) ? MC : DC;
        ref_result(op, a, b, p_hi, p_lo, p_dz);
      end else if (op == 4) m_hi = a;
      else if (op == 5) m_lo = a;
    end
  endfunction

  // One clock cycle: check stall mid-cycle, advance model at the edge, check state after.
  task automatic tick();
    @(negedge clk);
    last_stall = stall;
    check("stall", stall, md_in_d & ((m_left > 0) | start));
    @(posedge clk);
    model_edge();
    #1;
    check("busy", busy, m_left > 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    tick();
    start = 0;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{3'd0, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1]  = '{3'd1, 32'd3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, MC};
    vecs[2]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[7]  = '{3'd2, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[8]  = '{3'd4, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFD, 0};
    vecs[9]  = '{3'd5, 32'h12345678, 32'd0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[10] = '{3'd6, 32'h55555555, 32'd9,        32'hDEADBEEF, 32'h12345678, 0};

    // Reset state
    #3;
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_stall", stall, 0);
    #9 reset_n = 1;

    // Async reset in the middle of a MULT: aborts, clears, no later write
    issue(3'd4, 32'h11, 0);
    issue(3'd0, 32'd2, 32'd3);
    tick();
    #2 reset_n = 0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_hi", hi, 0);
    check("midrun_rst_lo", lo, 0);
    m_left = 0; m_hi = 0; m_lo = 0;
    #2 reset_n = 1;
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_write_hi", hi, 0);
    check("abort_no_write_lo", lo, 0);

    // Table vectors: latency in busy cycles and final HI/LO
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      cnt = 0;
      while (busy && cnt < 20) begin cnt++; tick(); end
      check($sformatf("vec%0d_cycles", i), cnt, vecs[i].ncyc);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
    end

    // Stall window with a second start ignored mid-flight
    md_in_d = 1;
    for (int i = 0; i <= 6; i++) begin
      start = (i == 0) || (i == 2);
      op    = (i == 0) ? 3'd0 : 3'd2;
      a     = (i == 0) ? 32'd5 : 32'd100;
      b     = (i == 0) ? 32'd6 : 32'd7;
      tick();
      check($sformatf("stall_k+%0d", i), last_stall, i <= 5);
    end
    start = 0; md_in_d = 0;
    check("second_start_ignored_hi", hi, 0);
    check("second_start_ignored_lo", lo, 30);

    // MTLO during RUN is dropped
    issue(3'd0, 32'd2, 32'd2);
    issue(3'd5, 32'hAAAA, 0);
    for (int i = 0; i < 6; i++) tick();
    check("mtlo_in_run_lo", lo, 4);
    check("mtlo_in_run_busy", busy, 0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom_range(0, 7));
      a       = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b       = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      md_in_d = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller, placed in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E, owns the HI/LO registers, and counts out the operation latency.
- Drives the stall request that holds a HI/LO-using instruction in D while the unit is busy.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO write for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles from accepted start to HI/LO write for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  E-stage instruction is an MD operation, valid this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op
- a  input  32  rs operand, already forwarded
- b  input  32  rt operand, already forwarded
- md_in_d  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- stall  output  1  hold F/D and flush E bubble

Behaviour:
- Reset (reset_n low, async):
  - state IDLE; busy=0, hi=0, lo=0, counter=0; latched operands and result cleared.
  - Reset mid-operation aborts it; no HI/LO write ever occurs from the aborted op.
- States:
  - IDLE -> RUN on start & op in {0..3}. At that edge: latch a, b, op; load counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: counter decrements each edge. On the edge where the counter equals 1: HI/LO are written, busy falls, state -> IDLE.
- Latency:
  - Start sampled at edge k; busy high during cycles k+1..k+N; new hi/lo visible after edge k+N.
  - busy is high for exactly N cycles.
- MTHI/MTLO (op 4/5) with start in IDLE:
  - hi<=a (or lo<=a) at that edge; busy stays 0; single cycle.
- Arithmetic:
  - MULT: 64-bit signed product; hi=upper 32, lo=lower 32.
  - MULTU: same as MULT, unsigned.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend a.
  - DIVU: same as DIV, unsigned.
  - Divide by zero (b==0): the op still runs DIV_CYCLES with busy, but hi/lo are left unchanged.
- Illegal or simultaneous events:
  - start while busy (any op) is ignored; the in-flight op completes unaffected.
  - op 6/7 with start is ignored in any state.
- stall = md_in_d & (busy | start), combinational.
  - Covers the cycle an MD op sits in E and every busy cycle.
  - stall is 0 on the cycle after busy falls; mfhi/mflo then read the new value.
- hi and lo are registered outputs; no combinational bypass of the pending result.

Test Plan:
- Reset mid-RUN: start MULT a=2,b=3, assert reset_n=0 at cycle 2 -> busy=0, hi=lo=0 immediately; no later write.
- MULT: a=3, b=FFFFFFFE -> busy high 5 cycles; hi=FFFFFFFF, lo=FFFFFFFA after edge k+5.
- MULTU: same operands -> hi=00000002, lo=FFFFFFFA.
- DIV and DIVU:
  - DIV a=7, b=FFFFFFFE -> busy high 10 cycles; lo=FFFFFFFD, hi=00000001.
  - DIVU a=7, b=2 -> lo=3, hi=1.
  - DIV b=0 -> busy 10 cycles; hi/lo unchanged.
- Stall window: start MULT with md_in_d=1 held -> stall=1 at cycle k and cycles k+1..k+5, 0 at k+6.
  - Second start issued at cycle k+2 -> ignored; result is from the first op.
- MTHI/MTLO:
  - MTHI a=DEADBEEF in IDLE -> hi=DEADBEEF next edge, busy never rises.
  - MTLO during RUN -> ignored.
